// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: access modes, FSM states and access-size decode.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    Load_byte       = 2'd0,
    Load_halfword   = 2'd1,
    Load_word       = 2'd2,
    Load_doubleword = 2'd3
  } load_mode_e;

  typedef enum logic [1:0] {
    LS_IDLE  = 2'd0,
    LS_BEAT1 = 2'd1,
    LS_BEAT2 = 2'd2,
    LS_RESP  = 2'd3
  } ls_state_e;

  function automatic logic [3:0] size_bytes(input load_mode_e mode);
    case (mode)
      Load_byte:     size_bytes = 4'd1;
      Load_halfword: size_bytes = 4'd2;
      Load_word:     size_bytes = 4'd4;
      default:       size_bytes = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_byte_lane_align.sv
// Byte-lane aligner over a two-word window: masks to size_i bytes and shifts by shamt_i bytes.
// SHIFT_LEFT=1 places right-aligned data onto lanes, SHIFT_LEFT=0 pulls lanes back to the right.
module load_store_unit_byte_lane_align #(
  parameter int NB         = 4,
  parameter bit SHIFT_LEFT = 1'b1
) (
  input  logic [16*NB-1:0]         data_i,
  input  logic [$clog2(2*NB)-1:0]  shamt_i,
  input  logic [3:0]               size_i,
  output logic [16*NB-1:0]         data_o
);

  logic [16*NB-1:0] mask;

  always_comb begin
    mask = '0;
    for (int i = 0; i < 2*NB; i++) begin
      if (i < int'(size_i)) mask[8*i +: 8] = 8'hFF;
    end
    if (SHIFT_LEFT) data_o = (data_i & mask) << {shamt_i, 3'b000};
    else            data_o = (data_i >> {shamt_i, 3'b000}) & mask;
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between issue stage and data RAM; variable-latency port, big-endian lanes.
// Define LS_UNALIGNED_SPLIT_EN to execute word-crossing accesses as two memory beats.
//   state    | meaning
//   LS_IDLE  | ready, latch request on req_valid
//   LS_BEAT1 | first (or only) memory beat, wait for mem_ack
//   LS_BEAT2 | second beat of a word-crossing access
//   LS_RESP  | one-cycle response pulse
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 32,
  parameter int MAWIDTH = AWIDTH - $clog2(DWIDTH / 8)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  load_mode_e            req_mode,
  input  logic                  req_exts,
  input  logic [AWIDTH-1:0]     req_addr,
  input  logic [DWIDTH-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DWIDTH-1:0]     resp_data,
  output logic                  resp_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DWIDTH/8-1:0]   mem_be,
  output logic [MAWIDTH-1:0]    mem_addr,
  output logic [DWIDTH-1:0]     mem_wdata,
  input  logic [DWIDTH-1:0]     mem_rdata,
  input  logic                  mem_ack
);

  localparam int NB = DWIDTH / 8;
  localparam int OW = $clog2(NB);
  localparam int SW = $clog2(2 * NB);
`ifdef LS_UNALIGNED_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  ls_state_e          state_q, state_d;
  logic               we_q, we_d, exts_q, exts_d, cross_q, cross_d, err_q, err_d;
  logic [3:0]         size_q, size_d;
  logic [OW-1:0]      off_q, off_d;
  logic [MAWIDTH-1:0] waddr_q, waddr_d;
  logic [DWIDTH-1:0]  wdata_q, wdata_d, rdata_q, rdata_d;

  logic [3:0]          req_size;
  logic [OW-1:0]       req_off;
  logic                req_cross, req_err;
  logic [SW-1:0]       shamt;
  logic [2*NB-1:0]     be_map;
  logic [2*DWIDTH-1:0] wr_out, rd_out;
  logic [DWIDTH-1:0]   rd_first, rd_second, rd_val, rd_ext;
  logic                unused_rd;

  // Access viewed as a byte stream across two adjacent words; shamt is its distance from the far end.
  always_comb begin
    req_size  = size_bytes(req_mode);
    req_off   = req_addr[OW-1:0];
    req_cross = (int'(req_off) + int'(req_size)) > NB;
    req_err   = ((req_mode == Load_doubleword) && (NB < 8)) || (req_cross && !SPLIT_EN);
    shamt     = SW'(2*NB - int'(off_q) - int'(size_q));
    for (int i = 0; i < 2*NB; i++) begin
      be_map[i] = (i >= int'(shamt)) && (i < int'(shamt) + int'(size_q));
    end
  end

`ifdef LS_UNALIGNED_SPLIT_EN
  logic [DWIDTH-1:0] hold_q, hold_d;

  always_comb begin
    hold_d = hold_q;
    if (state_q == LS_BEAT1 && mem_ack) hold_d = mem_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hold_q <= '0;
    else       hold_q <= hold_d;
  end

  assign rd_first  = (state_q == LS_BEAT2) ? hold_q : mem_rdata;
  assign rd_second = (state_q == LS_BEAT2) ? mem_rdata : '0;
`else
  assign rd_first  = mem_rdata;
  assign rd_second = '0;
`endif

  load_store_unit_byte_lane_align #(.NB(NB), .SHIFT_LEFT(1'b1)) u_wr_align (
    .data_i  ({{DWIDTH{1'b0}}, wdata_q}),
    .shamt_i (shamt),
    .size_i  (size_q),
    .data_o  (wr_out)
  );

  load_store_unit_byte_lane_align #(.NB(NB), .SHIFT_LEFT(1'b0)) u_rd_align (
    .data_i  ({rd_first, rd_second}),
    .shamt_i (shamt),
    .size_i  (size_q),
    .data_o  (rd_out)
  );

  assign unused_rd = ^rd_out[2*DWIDTH-1:DWIDTH];

  always_comb begin
    rd_val = rd_out[DWIDTH-1:0];
    rd_ext = rd_val;
    if (exts_q && size_q == 4'd1)      rd_ext = {{(DWIDTH-8){rd_val[7]}}, rd_val[7:0]};
    else if (exts_q && size_q == 4'd2) rd_ext = {{(DWIDTH-16){rd_val[15]}}, rd_val[15:0]};
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    exts_d  = exts_q;
    size_d  = size_q;
    off_d   = off_q;
    cross_d = cross_q;
    err_d   = err_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      LS_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          exts_d  = req_exts;
          size_d  = req_size;
          off_d   = req_off;
          cross_d = req_cross;
          err_d   = req_err;
          waddr_d = MAWIDTH'(req_addr >> OW);
          wdata_d = req_wdata;
          rdata_d = '0;
          state_d = req_err ? LS_RESP : LS_BEAT1;
        end
      end
      LS_BEAT1: begin
        if (mem_ack) begin
          if (cross_q) begin
            state_d = LS_BEAT2;
          end else begin
            state_d = LS_RESP;
            rdata_d = we_q ? '0 : rd_ext;
          end
        end
      end
      LS_BEAT2: begin
        if (mem_ack) begin
          state_d = LS_RESP;
          rdata_d = we_q ? '0 : rd_ext;
        end
      end
      default: state_d = LS_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == LS_IDLE);
    resp_valid = (state_q == LS_RESP);
    resp_err   = resp_valid && err_q;
    resp_data  = resp_valid ? rdata_q : '0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_be     = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (state_q == LS_BEAT1) begin
      mem_en    = 1'b1;
      mem_we    = we_q;
      mem_be    = be_map[2*NB-1:NB];
      mem_addr  = waddr_q;
      mem_wdata = we_q ? wr_out[2*DWIDTH-1:DWIDTH] : '0;
    end else if (state_q == LS_BEAT2) begin
      mem_en    = 1'b1;
      mem_we    = we_q;
      mem_be    = be_map[NB-1:0];
      mem_addr  = waddr_q + MAWIDTH'(1);
      mem_wdata = we_q ? wr_out[DWIDTH-1:0] : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LS_IDLE;
      we_q    <= 1'b0;
      exts_q  <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      cross_q <= 1'b0;
      err_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      exts_q  <= exts_d;
      size_q  <= size_d;
      off_q   <= off_d;
      cross_q <= cross_d;
      err_q   <= err_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: 32-bit unit with a wait-state memory model, 64-bit unit for address wrap.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_exts;
  load_mode_e  req_mode;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_data;
  logic        mem_en, mem_we, mem_ack;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic        req64_valid, req64_ready, req64_we, req64_exts;
  load_mode_e  req64_mode;
  logic [31:0] req64_addr;
  logic [63:0] req64_wdata;
  logic        resp64_valid, resp64_err;
  logic [63:0] resp64_data;
  logic        mem64_en, mem64_we, mem64_ack;
  logic [7:0]  mem64_be;
  logic [28:0] mem64_addr;
  logic [63:0] mem64_wdata, mem64_rdata;

  load_store_unit u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_mode(req_mode),
    .req_exts(req_exts), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  load_store_unit #(.DWIDTH(64)) u_dut64 (
    .clk(clk), .reset(reset),
    .req_valid(req64_valid), .req_ready(req64_ready), .req_we(req64_we), .req_mode(req64_mode),
    .req_exts(req64_exts), .req_addr(req64_addr), .req_wdata(req64_wdata),
    .resp_valid(resp64_valid), .resp_data(resp64_data), .resp_err(resp64_err),
    .mem_en(mem64_en), .mem_we(mem64_we), .mem_be(mem64_be), .mem_addr(mem64_addr),
    .mem_wdata(mem64_wdata), .mem_rdata(mem64_rdata), .mem_ack(mem64_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  // Memory model: acks after cfg_waits wait cycles, logs each beat, flags outputs moving during a wait.
  int          cfg_waits;
  logic [31:0] cfg_rd1, cfg_rd2;
  int          wait_cnt, beat_idx, en_cycles;
  logic        unstable;
  logic [29:0] a0;
  logic [3:0]  be0;
  logic [31:0] wd0;
  logic [29:0] b_addr[4];
  logic [3:0]  b_be[4];
  logic [31:0] b_wd[4];
  logic        b_we[4];

  initial begin
    cfg_waits = 0; cfg_rd1 = '0; cfg_rd2 = '0;
  end

  always @(posedge clk or negedge clk) begin
    if (clk) begin
      if (req_valid && req_ready) begin
        beat_idx = 0; en_cycles = 0; unstable = 1'b0;
      end
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      if (!mem_en) begin
        wait_cnt = 0;
      end else begin
        en_cycles++;
        if (wait_cnt == 0) begin
          a0 = mem_addr; be0 = mem_be; wd0 = mem_wdata;
        end else if (mem_addr !== a0 || mem_be !== be0 || mem_wdata !== wd0) begin
          unstable = 1'b1;
        end
        if (wait_cnt >= cfg_waits) begin
          mem_ack   = 1'b1;
          mem_rdata = (beat_idx == 0) ? cfg_rd1 : cfg_rd2;
          if (beat_idx < 4) begin
            b_addr[beat_idx] = mem_addr; b_be[beat_idx] = mem_be;
            b_wd[beat_idx] = mem_wdata;  b_we[beat_idx] = mem_we;
          end
          beat_idx++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  int          r_lat;
  logic [31:0] r_data;
  logic        r_err, r_busy_ready, r_after;

  // Entered and left on a falling edge; r_lat counts cycles from the accepting edge.
  task automatic run_req(input logic we, input load_mode_e mode, input logic exts,
                         input logic [31:0] addr, input logic [31:0] wdata, input int waits,
                         input logic [31:0] rd1, input logic [31:0] rd2);
    int k;
    cfg_waits = waits; cfg_rd1 = rd1; cfg_rd2 = rd2;
    req_we = we; req_mode = mode; req_exts = exts; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    k = 1;
    r_busy_ready = req_ready;
    while (!resp_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    r_lat  = resp_valid ? k : -1;
    r_data = resp_data;
    r_err  = resp_err;
    @(negedge clk);
    r_after = resp_valid;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic saw_resp, saw_en;
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_mode = Load_word; req_exts = 1'b0;
    req_addr = '0; req_wdata = '0;
    req64_valid = 1'b0; req64_we = 1'b0; req64_mode = Load_word; req64_exts = 1'b0;
    req64_addr = '0; req64_wdata = '0;
    mem64_ack = 1'b1; mem64_rdata = 64'h8899AABBCCDDEEFF;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    @(negedge clk);

    run_req(1'b0, Load_word, 1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF, 32'h0);
    check("lw_lat", r_lat, 2);
    check("lw_data", r_data, 32'hDEADBEEF);
    check("lw_err", r_err, 0);
    check("lw_addr", b_addr[0], 30'h40);
    check("lw_be", b_be[0], 4'b1111);
    check("lw_we", b_we[0], 0);
    check("lw_beats", beat_idx, 1);
    check("lw_busy_ready", r_busy_ready, 0);
    check("lw_pulse_once", r_after, 0);

    run_req(1'b0, Load_byte, 1'b1, 32'h103, 32'h0, 0, 32'h000000F0, 32'h0);
    check("lbs_be", b_be[0], 4'b0001);
    check("lbs_data", r_data, 32'hFFFFFFF0);
    check("lbs_lat", r_lat, 2);

    run_req(1'b0, Load_byte, 1'b0, 32'h101, 32'h0, 0, 32'h12F45678, 32'h0);
    check("lbu_be", b_be[0], 4'b0100);
    check("lbu_data", r_data, 32'h000000F4);

    run_req(1'b0, Load_halfword, 1'b1, 32'h102, 32'h0, 0, 32'h00008001, 32'h0);
    check("lhs_be", b_be[0], 4'b0011);
    check("lhs_data", r_data, 32'hFFFF8001);

    run_req(1'b0, Load_halfword, 1'b0, 32'h101, 32'h0, 1, 32'h11A2B344, 32'h0);
    check("lh_mis_lat", r_lat, 3);
    check("lh_mis_be", b_be[0], 4'b0110);
    check("lh_mis_data", r_data, 32'h0000A2B3);
    check("lh_mis_err", r_err, 0);

    run_req(1'b1, Load_halfword, 1'b0, 32'h105, 32'hFFFF1234, 1, 32'h0, 32'h0);
    check("sh_lat", r_lat, 3);
    check("sh_be", b_be[0], 4'b0110);
    check("sh_wdata", b_wd[0], 32'h00123400);
    check("sh_we", b_we[0], 1);
    check("sh_addr", b_addr[0], 30'h41);
    check("sh_resp_data", r_data, 0);
    check("sh_stable", unstable, 0);

    run_req(1'b1, Load_byte, 1'b0, 32'h102, 32'h555555AB, 0, 32'h0, 32'h0);
    check("sb_be", b_be[0], 4'b0010);
    check("sb_wdata", b_wd[0], 32'h0000AB00);

    run_req(1'b0, Load_doubleword, 1'b0, 32'h100, 32'h0, 0, 32'h12345678, 32'h0);
    check("ld32_lat", r_lat, 1);
    check("ld32_err", r_err, 1);
    check("ld32_mem_en", en_cycles, 0);
    check("ld32_data", r_data, 0);

    run_req(1'b0, Load_word, 1'b0, 32'h102, 32'h0, 2, 32'hAAAABBBB, 32'hCCCCDDDD);
`ifdef LS_UNALIGNED_SPLIT_EN
    check("split_lat", r_lat, 7);
    check("split_data", r_data, 32'hBBBBCCCC);
    check("split_err", r_err, 0);
    check("split_beats", beat_idx, 2);
    check("split_addr1", b_addr[0], 30'h40);
    check("split_addr2", b_addr[1], 30'h41);
    check("split_be1", b_be[0], 4'b0011);
    check("split_be2", b_be[1], 4'b1100);
    check("split_stable", unstable, 0);
`else
    check("nosplit_lat", r_lat, 1);
    check("nosplit_err", r_err, 1);
    check("nosplit_mem_en", en_cycles, 0);
    check("nosplit_data", r_data, 0);
`endif

    run_req(1'b1, Load_word, 1'b0, 32'h103, 32'h11223344, 0, 32'h0, 32'h0);
`ifdef LS_UNALIGNED_SPLIT_EN
    check("ssplit_lat", r_lat, 3);
    check("ssplit_be1", b_be[0], 4'b0001);
    check("ssplit_be2", b_be[1], 4'b1110);
    check("ssplit_wd1", b_wd[0], 32'h00000011);
    check("ssplit_wd2", b_wd[1], 32'h22334400);
`else
    check("snosplit_err", r_err, 1);
    check("snosplit_mem_en", en_cycles, 0);
`endif

    cfg_waits = 5; cfg_rd1 = 32'h0; cfg_rd2 = 32'h0;
    req_we = 1'b0; req_mode = Load_word; req_exts = 1'b0; req_addr = 32'h300;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rstmid_en_before", mem_en, 1);
    reset = 1'b1;
    #1;
    check("rstmid_en_drop", mem_en, 0);
    check("rstmid_be_drop", mem_be, 0);
    check("rstmid_no_resp", resp_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    saw_resp = 1'b0; saw_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid) saw_resp = 1'b1;
      if (mem_en) saw_en = 1'b1;
    end
    check("rstmid_resp_after", saw_resp, 0);
    check("rstmid_en_after", saw_en, 0);
    check("rstmid_ready", req_ready, 1);

    run_req(1'b0, Load_word, 1'b0, 32'h200, 32'h0, 0, 32'h01020304, 32'h0);
    check("post_rst_lat", r_lat, 2);
    check("post_rst_data", r_data, 32'h01020304);
    check("post_rst_addr", b_addr[0], 30'h80);

    req64_mode = Load_word; req64_exts = 1'b1; req64_addr = 32'hFFFFFFFE;
    req64_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req64_valid = 1'b0;
`ifdef LS_UNALIGNED_SPLIT_EN
    check("wrap_en1", mem64_en, 1);
    check("wrap_addr1", mem64_addr, 29'h1FFFFFFF);
    check("wrap_be1", mem64_be, 8'b00000011);
    @(negedge clk);
    check("wrap_en2", mem64_en, 1);
    check("wrap_addr2", mem64_addr, 0);
    check("wrap_be2", mem64_be, 8'b11000000);
    @(negedge clk);
    check("wrap_resp", resp64_valid, 1);
    check("wrap_data", resp64_data, 64'h00000000EEFF8899);
    check("wrap_err", resp64_err, 0);
`else
    check("wrap_resp", resp64_valid, 1);
    check("wrap_err", resp64_err, 1);
    check("wrap_mem_en", mem64_en, 0);
    check("wrap_data", resp64_data, 0);
`endif
    @(negedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Parametrised load/store unit sitting between the backend issue stage and the data RAM port. Accepts one access per request handshake, drives a variable-latency memory port, aligns and sign-extends read data, and returns one result per request. Generalises the single-cycle 32-bit unit: configurable data width, memory wait-states via acknowledge, and unaligned accesses split into two memory beats.

## Interface
- DWIDTH, 32: data width; 32 or 64; NB = DWIDTH/8 byte lanes.
- AWIDTH, 32: byte address width.
- MAWIDTH, AWIDTH-log2(NB): memory word-address width.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_mode  in  Load_mode  Load_byte/halfword/word/doubleword (doubleword legal only when DWIDTH=64).
- req_exts  in  1  sign-extend byte/halfword load result.
- req_addr  in  AWIDTH  byte address.
- req_wdata  in  DWIDTH  store data, right-aligned.
- resp_valid  out  1  one-cycle result pulse.
- resp_data  out  DWIDTH  load data, right-aligned; 0 for stores and errors.
- resp_err  out  1  alignment error, valid with resp_valid.
- mem_en  out  1  memory request, held until mem_ack.
- mem_we  out  1  write.
- mem_be  out  NB  byte enables, big-endian (offset 0 = be[NB-1]).
- mem_addr  out  MAWIDTH  word address.
- mem_wdata  out  DWIDTH  lane-aligned write data.
- mem_rdata  in  DWIDTH  read data, valid with mem_ack.
- mem_ack  in  1  completes current beat; only sampled while mem_en.

## Operation
- FSM: IDLE, BEAT1, BEAT2, RESP.
- IDLE: req_ready=1. On req_valid, latch request; compute size S (1/2/4/8 bytes), offset o = addr mod NB. Access crosses word if o+S > NB.
- Misaligned per rule: offset not multiple of S. Non-crossing misaligned accesses are legal (halfword at o=1 uses lanes 1..2).
- Crossing access: with split enabled -> BEAT1; without -> RESP with resp_err=1, no memory traffic. Non-crossing -> BEAT1.
- BEAT1: mem_en=1, mem_addr = addr/NB, be covers bytes o..min(o+S,NB)-1. On mem_ack: if crossing -> BEAT2 (store beat-1 read bytes in hold register), else -> RESP.
- BEAT2: mem_addr = addr/NB + 1 modulo 2^MAWIDTH (wraps to 0), be covers lanes 0..(o+S-NB)-1. On mem_ack -> RESP.
- RESP: resp_valid=1 one cycle, then IDLE. Load data = concatenation hold||beat-2 bytes (big-endian), right-aligned, masked to S bytes; if req_exts and S<4 bytes, sign-extend from bit 8*S-1, else zero-extend.
- Stores: req_wdata low S bytes rotated to the enabled lanes; each beat carries its slice.
- Unused mem_be lanes 0; mem_we=0 outside BEAT states.
- Doubleword request with DWIDTH=32: resp_err=1, no memory traffic.

## Timing
- Reset values: req_ready=1 after reset release, resp_valid=0, resp_err=0, resp_data=0, mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
- Accept at cycle T -> mem_en from T+1. Zero-wait ack at T+1 -> resp_valid at T+2. Each wait state adds one cycle; split adds beat-2 cycles.
- Error path: resp_valid at T+1.
- Request inputs ignored outside IDLE; next accept earliest the cycle after RESP.
- mem_en, mem_addr, mem_be, mem_wdata stable while waiting for ack.
- reset mid-beat: outputs drop immediately, no resp, memory transaction abandoned.

## Configuration
- LS_UNALIGNED_SPLIT_EN defined: crossing accesses execute as two beats, resp_err never set for them.
- Undefined: BEAT2 and hold register removed; crossing accesses return resp_err=1 at T+1 with no memory access.

## Structure
- Pu_types: Load_mode extended with Load_doubleword; Ls_state enum; size-decode function.
- Sub-module byte_lane_align: parametrised NB-lane byte rotate plus mask, instanced once for write path and once for read path.

## Test plan
- DWIDTH=32, load word @0x100, mem_rdata=0xDEADBEEF, ack zero-wait -> resp at T+2, data 0xDEADBEEF, err 0.
- Load byte @0x103, exts=1, rdata=0x000000F0 -> mem_be=0001, resp_data 0xFFFFFFF0.
- Store halfword 0x1234 @0x105 -> mem_be=0110, mem_wdata=0x00123400, mem_we=1.
- Split on: load word @0x102, beat1 rdata=0xAAAABBBB, beat2 0xCCCCDDDD, 2 wait states each -> addr 0x40 then 0x41, be 0011 then 1100, resp_data 0xBBBBCCCC at T+7. Split off: same stimulus -> resp_err=1 at T+1, mem_en never high.
- Split wrap: DWIDTH=64, load word @0xFFFFFFFE -> beat-2 mem_addr=0.
- Assert reset during BEAT1 wait -> mem_en low same cycle, no resp_valid, next request served normally.
